// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {Instr, PC+4, PC} tuples.
// The head entry is presented combinationally; a redirect flush drops every entry.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         InstrF,
  input  logic [WIDTH-1:0]         PC4F,
  input  logic [WIDTH-1:0]         PCF,
  input  logic                     ValidF,
  output logic                     PCEn,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic [WIDTH-1:0]         InstrD,
  output logic [WIDTH-1:0]         PC4D,
  output logic [WIDTH-1:0]         PCD,
  output logic                     ValidD,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] pc4_q   [DEPTH];
  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [PtrW-1:0]  rp_q, wp_q;
  logic [CntW-1:0]  count_q;

  logic push, pop;

  always_comb begin
    ValidD = (count_q != '0);
    pop    = ValidD & ~StallD;
    // A full queue still accepts when decode drains the head in the same cycle.
    PCEn   = (count_q < CntW'(DEPTH)) | pop;
    push   = ValidF & PCEn;
    Count  = count_q;
    InstrD = ValidD ? instr_q[rp_q] : '0;
    PC4D   = ValidD ? pc4_q[rp_q]   : '0;
    PCD    = ValidD ? pc_q[rp_q]    : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
        pc_q[i]    <= '0;
      end
    end else if (FlushD) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        instr_q[wp_q] <= InstrF;
        pc4_q[wp_q]   <= PC4F;
        pc_q[wp_q]    <= PCF;
        wp_q          <= wp_q + PtrW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule
